memstream_cfg_sched: RTL and testbench

- Scheduler that shares the single ap_memory-style config port of a memstream instance between two requesters.
- Requester 1 is the host: the IP-side interface of the AXI-lite adapter.
- Requester 2 is a bulk weight loader fed by an AXI-stream. It writes a programmed number of words into consecutive memstream addresses.
- The block sits between axi4lite_if, the weight DMA stream and memstream. Host accesses always win; the loader fills the remaining cycles.

---
 rtl/memstream_cfg_sched.sv | 87 ++++++++
 tb/tb_memstream_cfg_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memstream_cfg_sched.sv
// memstream_cfg_sched: shares memstream's config port between host accesses and a streamed bulk loader
module memstream_cfg_sched #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int CW = $clog2(DEPTH+1),
  parameter int AW = $clog2(DEPTH),
  parameter int SW = ((WIDTH+7)/8)*8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_en,
  input  logic             host_wen,
  input  logic [31:0]      host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_rack,
  output logic [WIDTH-1:0] host_rdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [SW-1:0]    s_axis_tdata,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic [CW-1:0]    load_count,
  output logic             load_busy,
  output logic             load_done,
  output logic             config_ce,
  output logic             config_we,
  output logic [31:0]      config_address,
  output logic [WIDTH-1:0] config_d0,
  input  logic [WIDTH-1:0] config_q0,
  input  logic             config_rack
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t r_state;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_idx, r_cnt;
  logic r_rd_pend;
  logic w_beat, w_last;
  // host always wins; a pending host read stalls the loader to keep read-after-write order
  assign s_axis_tready = (r_state == LOAD) & ~host_en & ~r_rd_pend;
  assign w_beat = s_axis_tvalid & s_axis_tready;
  assign w_last = r_idx == r_cnt - CW'(1);
  assign load_busy = r_state != IDLE;
  assign host_rack = config_rack & r_rd_pend;
  assign host_rdata = config_q0;
  always_ff @(posedge clk) begin
    if (rst) begin
      config_ce <= 1'b0;
      config_we <= 1'b0;
      config_address <= '0;
      config_d0 <= '0;
      load_done <= 1'b0;
      r_state <= IDLE;
      r_addr <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      config_ce <= host_en | w_beat;
      config_we <= host_en ? host_wen : w_beat;
      if (host_en | w_beat) begin
        config_address <= host_en ? host_addr : 32'(r_addr);
        config_d0 <= host_en ? host_wdata : s_axis_tdata[WIDTH-1:0];
      end
      r_rd_pend <= (host_en & ~host_wen) | (r_rd_pend & ~config_rack);
      load_done <= 1'b0;
      case (r_state)
        IDLE: if (load_start) begin
          r_addr <= load_base;
          r_cnt <= load_count;
          r_idx <= '0;
          r_state <= (load_count != '0) ? LOAD : IDLE;
          load_done <= (load_count == '0);
        end
        LOAD: if (w_beat) begin
          r_idx <= r_idx + CW'(1);
          // explicit wrap so non-power-of-two depths stay in range
          r_addr <= (r_addr == AW'(DEPTH-1)) ? '0 : r_addr + AW'(1);
          if (w_last) begin
            r_state <= DONE;
            load_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memstream_cfg_sched.sv
// tb_memstream_cfg_sched: scoreboard bench for two scheduler instances (DEPTH 16 and 12)
module tb_memstream_cfg_sched;
  localparam int W = 32;
  typedef struct {int stamp; logic we; logic [31:0] addr; logic [W-1:0] d;} acc_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic host_en [2], host_wen [2], host_rack [2], s_tvalid [2], s_tready [2];
  logic load_start [2], load_busy [2], load_done [2], ce [2], we [2];
  logic rack [2], env_rack [2], stray [2];
  logic [31:0] host_addr [2], addr [2];
  logic [W-1:0] host_wdata [2], host_rdata [2], tdata [2], d0 [2], q0 [2];
  logic [3:0] load_base [2];
  logic [4:0] load_count [2];
  int dep [2] = '{16, 12};
  int checks = 0, errors = 0, cyc = 0;
  acc_t eq [2][$];
  logic [W-1:0] rq [2][$];
  acc_t mon_e;
  logic [W-1:0] mem [2][16] = '{default: '0};
  logic [W-1:0] mm [2][16] = '{default: '0};
  int m_left [2], m_base [2], m_n [2], cd [2];
  bit m_tail [2], m_zero [2], m_pend [2], held [2], rv [2];
  logic [W-1:0] rbuf [2];
  memstream_cfg_sched #(.DEPTH(16), .WIDTH(W)) u0 (
    .clk(clk), .rst(rst), .host_en(host_en[0]), .host_wen(host_wen[0]), .host_addr(host_addr[0]),
    .host_wdata(host_wdata[0]), .host_rack(host_rack[0]), .host_rdata(host_rdata[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tdata(tdata[0]),
    .load_start(load_start[0]), .load_base(load_base[0]), .load_count(load_count[0]),
    .load_busy(load_busy[0]), .load_done(load_done[0]), .config_ce(ce[0]), .config_we(we[0]),
    .config_address(addr[0]), .config_d0(d0[0]), .config_q0(q0[0]), .config_rack(rack[0]));
  memstream_cfg_sched #(.DEPTH(12), .WIDTH(W)) u1 (
    .clk(clk), .rst(rst), .host_en(host_en[1]), .host_wen(host_wen[1]), .host_addr(host_addr[1]),
    .host_wdata(host_wdata[1]), .host_rack(host_rack[1]), .host_rdata(host_rdata[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tdata(tdata[1]),
    .load_start(load_start[1]), .load_base(load_base[1]), .load_count(load_count[1][3:0]),
    .load_busy(load_busy[1]), .load_done(load_done[1]), .config_ce(ce[1]), .config_we(we[1]),
    .config_address(addr[1]), .config_d0(d0[1]), .config_q0(q0[1]), .config_rack(rack[1]));
  assign rack[0] = env_rack[0] | stray[0];
  assign rack[1] = env_rack[1] | stray[1];
  always @(posedge clk) cyc <= cyc + 1;
  // memstream emulation: reads acknowledge 2..4 cycles after config_ce
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      env_rack[k] <= 1'b0;
      if (rst) begin
        rv[k] <= 0;
        q0[k] <= '0;
      end else begin
        if (rv[k]) begin
          if (cd[k] == 0) begin
            env_rack[k] <= 1'b1;
            q0[k] <= rbuf[k];
            rv[k] <= 0;
          end else cd[k] <= cd[k] - 1;
        end
        if (ce[k] && we[k]) mem[k][addr[k][3:0]] <= d0[k];
        if (ce[k] && !we[k]) begin
          rv[k] <= 1;
          cd[k] <= int'($urandom_range(0, 2));
          rbuf[k] <= mem[k][addr[k][3:0]];
        end
      end
    end
  end
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask
  // monitor: pops the scoreboard whenever a config access or host read ack appears
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ce[k]) begin
        if (eq[k].size() == 0) begin
          checks++; errors++;
          $display("FAIL ce[%0d] unexpected cyc %0d addr %h", k, cyc, addr[k]);
        end else begin
          mon_e = eq[k].pop_front();
          chk("ce_cycle", k, cyc, mon_e.stamp + 1);
          chk("we", k, we[k], mon_e.we);
          chk("addr", k, addr[k], mon_e.addr);
          chk("d0", k, d0[k], mon_e.d);
        end
      end else if (eq[k].size() > 0 && eq[k][0].stamp + 1 <= cyc) begin
        mon_e = eq[k].pop_front();
        checks++; errors++;
        $display("FAIL ce[%0d] missing cyc %0d want addr %h", k, cyc, mon_e.addr);
      end
      if (host_rack[k]) begin
        if (rq[k].size() == 0) begin
          checks++; errors++;
          $display("FAIL hrack[%0d] unexpected cyc %0d", k, cyc);
        end else chk("hrdata", k, host_rdata[k], rq[k].pop_front());
      end
    end
  end
  // reference: a load is "remaining words"; output k goes to (base + words written) mod depth
  task automatic model(int k);
    bit rdy, beat, bsy;
    int a;
    bsy = m_left[k] > 0 || m_tail[k];
    rdy = m_left[k] > 0 && !host_en[k] && !m_pend[k];
    chk("tready", k, s_tready[k], rdy);
    chk("busy", k, load_busy[k], bsy);
    chk("done", k, load_done[k], m_tail[k] || m_zero[k]);
    chk("hrack", k, host_rack[k], rack[k] && m_pend[k]);
    if (rst) begin
      m_left[k] = 0; m_tail[k] = 0; m_zero[k] = 0; m_pend[k] = 0; held[k] = 0;
      rq[k].delete();
      return;
    end
    beat = s_tvalid[k] && rdy;
    m_tail[k] = 0;
    m_zero[k] = 0;
    if (host_en[k]) begin
      eq[k].push_back('{cyc, host_wen[k], host_addr[k], host_wdata[k]});
      if (host_wen[k]) mm[k][host_addr[k][3:0]] = host_wdata[k];
      else rq[k].push_back(mm[k][host_addr[k][3:0]]);
    end else if (beat) begin
      a = (m_base[k] + m_n[k]) % dep[k];
      eq[k].push_back('{cyc, 1'b1, 32'(a), tdata[k]});
      mm[k][a] = tdata[k];
      m_n[k]++;
      m_left[k]--;
      if (m_left[k] == 0) m_tail[k] = 1;
    end
    if (!bsy && load_start[k]) begin
      if (load_count[k] == 0) m_zero[k] = 1;
      else begin
        m_left[k] = int'(load_count[k]);
        m_base[k] = int'(load_base[k]);
        m_n[k] = 0;
      end
    end
    if (host_en[k] && !host_wen[k]) m_pend[k] = 1;
    else if (rack[k]) m_pend[k] = 0;
    held[k] = s_tvalid[k] && !beat;
  endtask
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) model(k);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      host_en[k] = 0; host_wen[k] = 0; host_addr[k] = 0; host_wdata[k] = 0;
      load_start[k] = 0; load_base[k] = 0; load_count[k] = 0;
      s_tvalid[k] = held[k]; stray[k] = 0;
    end
  endtask
  task automatic reset_chk(int k);
    chk("rst_ce", k, ce[k], 0);
    chk("rst_we", k, we[k], 0);
    chk("rst_addr", k, addr[k], 0);
    chk("rst_d0", k, d0[k], 0);
    chk("rst_tready", k, s_tready[k], 0);
    chk("rst_busy", k, load_busy[k], 0);
    chk("rst_done", k, load_done[k], 0);
    chk("rst_hrack", k, host_rack[k], 0);
    chk("rst_hrdata", k, host_rdata[k], 0);
  endtask
  task automatic load(int k, int b, int n);
    load_start[k] = 1; load_base[k] = 4'(b); load_count[k] = 5'(n);
    tick();
    load_start[k] = 0;
  endtask
  task automatic beats(int k, int n, logic [W-1:0] base);
    int i = 0, g = 0;
    while (i < n && g < 100) begin
      s_tvalid[k] = 1; tdata[k] = base + W'(i);
      tick();
      g++;
      if (!held[k]) i++;
    end
    s_tvalid[k] = 0;
    chk("beats_taken", k, i, n);
  endtask
  task automatic rand_inputs(int k);
    load_start[k] = ($urandom_range(0, 9) == 0);
    load_count[k] = 5'($urandom_range(0, dep[k]));
    load_base[k] = 4'($urandom_range(0, dep[k] - 1));
    host_en[k] = ($urandom_range(0, 4) == 0);
    host_wen[k] = m_pend[k] ? 1'b1 : 1'($urandom_range(0, 1));
    host_addr[k] = $urandom_range(0, dep[k] - 1);
    host_wdata[k] = $urandom;
    if (!held[k]) begin
      s_tvalid[k] = ($urandom_range(0, 3) != 0);
      tdata[k] = $urandom;
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) tdata[k] = '0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_chk(0); reset_chk(1);
    rst = 0;
    tick();
    load(0, 0, 4); beats(0, 4, 'hA0); repeat (3) tick();
    load(0, 14, 4); beats(0, 4, 'hD0); repeat (3) tick();
    load(1, 10, 3); beats(1, 3, 'hE0); repeat (3) tick();
    load(0, 2, 6);
    s_tvalid[0] = 1; tdata[0] = 'hB0;
    host_en[0] = 1; host_wen[0] = 1; host_addr[0] = 5; host_wdata[0] = 'h55;
    tick();
    host_en[0] = 0; host_wen[0] = 0;
    beats(0, 6, 'hB0); repeat (3) tick();
    load(0, 0, 6); beats(0, 4, 'hC0);
    s_tvalid[0] = 1; tdata[0] = 'hC4;
    host_en[0] = 1; host_wen[0] = 0; host_addr[0] = 3;
    tick();
    host_en[0] = 0;
    beats(0, 2, 'hC4); repeat (3) tick();
    load(0, 0, 0); repeat (3) tick();
    load(0, 4, 3); load(0, 9, 5); beats(0, 3, 'h40); repeat (4) tick();
    load(0, 0, 8); beats(0, 2, 'hF0);
    idle(); rst = 1;
    tick();
    reset_chk(0); reset_chk(1);
    rst = 0;
    stray[0] = 1; stray[1] = 1;
    tick();
    stray[0] = 0; stray[1] = 0;
    tick();
    load(0, 6, 3); beats(0, 3, 'h60); repeat (3) tick();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) rand_inputs(k);
      tick();
    end
    idle();
    repeat (12) begin idle(); tick(); end
    for (int k = 0; k < 2; k++) begin
      chk("eq_drain", k, eq[k].size(), 0);
      chk("rq_drain", k, rq[k].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1);
  end
endmodule
